// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the memory read port, the PC redirect input and the instruction
//   valid/ready handshake of the multicycle instruction fetch engine.
//
//   master : the fetch unit itself (drives memread/adr and the instruction)
//   slave  : the environment (memory, branch logic, decoder)
//
//   memdata     MEMW   read data, valid while memack is high
//   memack      1      memory completes the current read
//   memread     1      read request, held until memack
//   adr         WIDTH  byte address of the current beat
//   redirect    1      load redirect_pc, abort current fetch
//   redirect_pc WIDTH  redirect target
//   instr_valid 1      instr/instr_pc/pc_next valid
//   instr_ready 1      consumer accepts the instruction
//   instr       32     assembled instruction
//   instr_pc    WIDTH  byte address of instr
//   pc_next     WIDTH  instr_pc + 4
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int WIDTH = 8,
  parameter int MEMW  = 8
);
  logic [MEMW-1:0]  memdata;
  logic             memack;
  logic             memread;
  logic [WIDTH-1:0] adr;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [WIDTH-1:0] instr_pc;
  logic [WIDTH-1:0] pc_next;

  modport master (
    input  memdata, memack, redirect, redirect_pc, instr_ready,
    output memread, adr, instr_valid, instr, instr_pc, pc_next
  );

  modport slave (
    output memdata, memack, redirect, redirect_pc, instr_ready,
    input  memread, adr, instr_valid, instr, instr_pc, pc_next
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Multicycle instruction fetch engine. Assembles a 32-bit instruction from a
//   MEMW-bit memory port over BEATS = 32/MEMW reads, tolerating wait states,
//   and presents it through a valid/ready handshake. A redirect loads a new
//   PC and aborts any fetch in progress.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    instr_fetch_unit_if.master (memory port, redirect, handshake)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int               WIDTH    = 8,
  parameter int               MEMW     = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_unit_if.master    bus
);

  localparam int BEATS = 32 / MEMW;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STEP  = MEMW / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] beat_off_s;

  // Next-state logic: FSM transitions, beat assembly and PC update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    beat_d  = beat_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: begin
        // Redirect is deliberately ignored here: the first fetch always
        // starts at the reset PC.
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.redirect) begin
          // Any beat completing in this cycle is dropped.
          pc_d    = bus.redirect_pc;
          beat_d  = '0;
          state_d = ST_FETCH;
        end else if (bus.memack) begin
          for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BW'(b)) begin
              instr_d[b*MEMW +: MEMW] = bus.memdata;
            end else begin
              instr_d[b*MEMW +: MEMW] = instr_q[b*MEMW +: MEMW];
            end
          end
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_HOLD;
          end else begin
            beat_d  = beat_q + BW'(1);
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (bus.redirect) begin
          // Counts as acceptance if instr_ready is also high; the redirect
          // target replaces the sequential pc + 4.
          pc_d    = bus.redirect_pc;
          beat_d  = '0;
          state_d = ST_FETCH;
        end else if (bus.instr_ready) begin
          pc_d    = pc_q + WIDTH'(4);
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        // Unreachable encoding: restart cleanly from IDLE.
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      beat_q  <= '0;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      beat_q  <= beat_d;
      instr_q <= instr_d;
    end
  end

  // Byte offset of the current beat within the instruction word.
  always_comb begin
    beat_off_s = WIDTH'(beat_q) * WIDTH'(STEP);
  end

  // Outputs decode registered state only, so no input reaches an output
  // combinationally.
  assign bus.memread     = (state_q == ST_FETCH);
  assign bus.instr_valid = (state_q == ST_HOLD);
  assign bus.adr         = pc_q + beat_off_s;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = pc_q;
  assign bus.pc_next     = pc_q + WIDTH'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [7:0] mem [0:255];

  instr_fetch_unit_if #(.WIDTH(8), .MEMW(8))  if8  ();
  instr_fetch_unit_if #(.WIDTH(8), .MEMW(16)) if16 ();
  instr_fetch_unit_if #(.WIDTH(8), .MEMW(32)) if32 ();

  instr_fetch_unit #(.WIDTH(8), .MEMW(8),  .RESET_PC(8'h10)) dut8  (.clk(clk), .reset(reset), .bus(if8));
  instr_fetch_unit #(.WIDTH(8), .MEMW(16), .RESET_PC(8'h10)) dut16 (.clk(clk), .reset(reset), .bus(if16));
  instr_fetch_unit #(.WIDTH(8), .MEMW(32), .RESET_PC(8'h10)) dut32 (.clk(clk), .reset(reset), .bus(if32));

  // Little-endian memory image seen by all three instances.
  assign if8.memdata  = mem[if8.adr];
  assign if16.memdata = {mem[if16.adr + 8'd1], mem[if16.adr]};
  assign if32.memdata = {mem[if32.adr + 8'd3], mem[if32.adr + 8'd2],
                         mem[if32.adr + 8'd1], mem[if32.adr]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'h78; mem[8'h11] = 8'h56; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;

    reset = 1'b0;
    if8.memack  = 1'b1; if8.instr_ready  = 1'b0; if8.redirect  = 1'b0; if8.redirect_pc  = 8'h00;
    if16.memack = 1'b1; if16.instr_ready = 1'b0; if16.redirect = 1'b0; if16.redirect_pc = 8'h00;
    if32.memack = 1'b1; if32.instr_ready = 1'b0; if32.redirect = 1'b0; if32.redirect_pc = 8'h00;

    // Reset values
    tick; tick;
    chk("rst_memread",  32'(if8.memread),     32'h0);
    chk("rst_adr",      32'(if8.adr),         32'h10);
    chk("rst_valid",    32'(if8.instr_valid), 32'h0);
    chk("rst_instr",    if8.instr,            32'h0);
    chk("rst_instr_pc", 32'(if8.instr_pc),    32'h10);
    chk("rst_pc_next",  32'(if8.pc_next),     32'h14);
    chk("rst_valid16",  32'(if16.instr_valid), 32'h0);
    chk("rst_valid32",  32'(if32.instr_valid), 32'h0);

    // Release reset; one IDLE cycle before the first read
    reset = 1'b1;
    #1;
    chk("idle_memread", 32'(if8.memread), 32'h0);
    tick;
    chk("f0_memread8",  32'(if8.memread),  32'h1);
    chk("f0_adr8",      32'(if8.adr),      32'h10);
    chk("f0_adr16",     32'(if16.adr),     32'h10);
    chk("f0_adr32",     32'(if32.adr),     32'h10);
    chk("f0_memread32", 32'(if32.memread), 32'h1);
    tick;
    chk("f1_adr8",      32'(if8.adr),          32'h11);
    chk("f1_adr16",     32'(if16.adr),         32'h12);
    chk("w32_valid",    32'(if32.instr_valid), 32'h1);
    chk("w32_instr",    if32.instr,            32'h12345678);
    chk("w32_memread",  32'(if32.memread),     32'h0);
    tick;
    chk("f2_adr8",      32'(if8.adr),          32'h12);
    chk("w16_valid",    32'(if16.instr_valid), 32'h1);
    chk("w16_instr",    if16.instr,            32'h12345678);
    chk("w16_pc_next",  32'(if16.pc_next),     32'h14);

    // Wait states on beat 2
    if8.memack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_adr",     32'(if8.adr),         32'h12);
      chk("stall_memread", 32'(if8.memread),     32'h1);
      chk("stall_valid",   32'(if8.instr_valid), 32'h0);
    end
    if8.memack = 1'b1;
    tick;
    chk("f3_adr8", 32'(if8.adr), 32'h13);
    tick;
    chk("h0_valid",    32'(if8.instr_valid), 32'h1);
    chk("h0_instr",    if8.instr,            32'h12345678);
    chk("h0_instr_pc", 32'(if8.instr_pc),    32'h10);
    chk("h0_pc_next",  32'(if8.pc_next),     32'h14);
    chk("h0_memread",  32'(if8.memread),     32'h0);

    // Backpressure in HOLD
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("bp_valid",   32'(if8.instr_valid), 32'h1);
      chk("bp_instr",   if8.instr,            32'h12345678);
      chk("bp_memread", 32'(if8.memread),     32'h0);
    end
    if8.instr_ready = 1'b1;
    tick;
    if8.instr_ready = 1'b0;
    chk("acc_adr",      32'(if8.adr),         32'h14);
    chk("acc_valid",    32'(if8.instr_valid), 32'h0);
    chk("acc_instr_pc", 32'(if8.instr_pc),    32'h14);
    tick;
    chk("n1_adr", 32'(if8.adr), 32'h15);

    // Redirect mid-fetch with memack on beat 1: that beat is dropped
    if8.redirect = 1'b1; if8.redirect_pc = 8'h40;
    tick;
    if8.redirect = 1'b0;
    chk("rd_adr",     32'(if8.adr),     32'h40);
    chk("rd_memread", 32'(if8.memread), 32'h1);
    chk("rd_discard", if8.instr,        32'h12345614);
    tick; tick; tick;
    chk("rd_adr3", 32'(if8.adr), 32'h43);
    tick;
    chk("rd_valid",    32'(if8.instr_valid), 32'h1);
    chk("rd_instr",    if8.instr,            32'h43424140);
    chk("rd_instr_pc", 32'(if8.instr_pc),    32'h40);
    chk("rd_pc_next",  32'(if8.pc_next),     32'h44);

    // Redirect and ready together in HOLD
    if8.instr_ready = 1'b1; if8.redirect = 1'b1; if8.redirect_pc = 8'h80;
    tick;
    if8.instr_ready = 1'b0; if8.redirect = 1'b0;
    chk("rr_adr",   32'(if8.adr),         32'h80);
    chk("rr_valid", 32'(if8.instr_valid), 32'h0);
    tick; tick; tick; tick;
    chk("rr_instr",   if8.instr,         32'h83828180);
    chk("rr_pc_next", 32'(if8.pc_next),  32'h84);

    // Wrap-around at 0xFC
    if8.redirect = 1'b1; if8.redirect_pc = 8'hFC;
    tick;
    if8.redirect = 1'b0;
    chk("wr_adr0", 32'(if8.adr), 32'hFC);
    tick; tick; tick;
    chk("wr_adr3", 32'(if8.adr), 32'hFF);
    tick;
    chk("wr_instr",    if8.instr,         32'hFFFEFDFC);
    chk("wr_instr_pc", 32'(if8.instr_pc), 32'hFC);
    chk("wr_pc_next",  32'(if8.pc_next),  32'h00);
    if8.instr_ready = 1'b1;
    tick;
    if8.instr_ready = 1'b0;
    chk("wr_next_adr", 32'(if8.adr),     32'h00);
    chk("wr_next_pcn", 32'(if8.pc_next), 32'h04);
    tick; tick; tick; tick;
    chk("wr_instr0", if8.instr, 32'h03020100);
    chk("w16_still_valid", 32'(if16.instr_valid), 32'h1);

    // Reset during HOLD: outputs return immediately
    reset = 1'b0;
    #1;
    chk("hr_valid",   32'(if8.instr_valid),  32'h0);
    chk("hr_instr",   if8.instr,             32'h0);
    chk("hr_adr",     32'(if8.adr),          32'h10);
    chk("hr_memread", 32'(if8.memread),      32'h0);
    chk("hr_valid16", 32'(if16.instr_valid), 32'h0);

    // Redirect in IDLE is ignored
    if8.redirect = 1'b1; if8.redirect_pc = 8'h40;
    tick;
    reset = 1'b1;
    tick;
    if8.redirect = 1'b0;
    chk("idle_rd_adr",     32'(if8.adr),     32'h10);
    chk("idle_rd_memread", 32'(if8.memread), 32'h1);
    tick;
    chk("idle_rd_adr1", 32'(if8.adr), 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised multicycle instruction fetch engine for the MIPS-subset cores. It assembles each 32-bit instruction from a memory port MEMW bits wide (8, 16 or 32) over 32/MEMW beats, tolerating memory wait states. It presents the finished instruction to the controller/decoder through a valid/ready handshake and accepts a PC redirect from branch/jump logic that aborts any fetch in progress. It replaces the fixed four-cycle byte fetch (FETCH1..FETCH4 states plus the IR byte registers) of the 8-bit datapath.

## Interface
- WIDTH, 8, address/PC width in bits
- MEMW, 8, memory data width; legal values 8, 16, 32; BEATS = 32/MEMW
- RESET_PC, 0, PC value loaded at reset (WIDTH bits)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- memdata  in  MEMW  read data, valid in the cycle memack is high
- memack  in  1  memory completes the current read this cycle
- memread  out  1  read request; held high until memack
- adr  out  WIDTH  byte address of current beat
- redirect  in  1  load new PC, abort current fetch
- redirect_pc  in  WIDTH  target PC for redirect
- instr_valid  out  1  instr/instr_pc/pc_next valid
- instr_ready  in  1  consumer accepts instruction
- instr  out  32  assembled instruction, first beat in bits [MEMW-1:0]
- instr_pc  out  WIDTH  byte address of instr
- pc_next  out  WIDTH  instr_pc + 4, for branch/link base

## Operation
- Registers: pc (WIDTH), beat counter (log2 BEATS bits, min 1), instr (32), state.
- States: IDLE, FETCH, HOLD.
- IDLE: entered only from reset; memread=0; next state FETCH unconditionally.
- FETCH: memread=1, adr = pc + beat*(MEMW/8), mod 2^WIDTH. On memack: instr[beat*MEMW +: MEMW] <= memdata, beat++. On memack with beat = BEATS-1: beat <= 0, go to HOLD. Without memack: stay, all registers hold, adr stable.
- HOLD: instr_valid=1, memread=0. On instr_ready: pc <= pc + 4 (wraps mod 2^WIDTH), go to FETCH. Otherwise hold, outputs stable.
- instr_pc = pc; pc_next = pc + 4; both valid whenever instr_valid.
- Redirect (any state but IDLE): pc <= redirect_pc, beat <= 0, state <= FETCH. Beat data arriving with memack in that cycle is discarded. Redirect wins over memack and over instr_ready. A HOLD instruction with instr_ready=1 in the same cycle counts as accepted, but its pc+4 update is replaced by redirect_pc.
- Redirect in IDLE is ignored.
- redirect_pc is used unaligned as given. Alignment is the producer's responsibility.
- instr bits not yet written in the current fetch keep their previous value. They are only meaningful when instr_valid=1.

## Timing
- While reset=0, asynchronously: state=IDLE, pc=RESET_PC, beat=0, instr=0. Outputs: memread=0, adr=RESET_PC, instr_valid=0, instr=0, instr_pc=RESET_PC, pc_next=RESET_PC+4.
- Reset asserted mid-fetch or in HOLD: immediate return to the values above; the partial instruction is lost.
- First memread high is in the second rising-edge cycle after reset deassertion (one IDLE cycle).
- memread, adr and instr_valid are combinational from registered state only; no input-to-output combinational path.
- memack is sampled only while memread=1 and ignored otherwise.
- With memack tied high: instr_valid rises BEATS cycles after entering FETCH. Throughput with instr_ready tied high is one instruction per BEATS+1 cycles (MEMW=8: 5; 16: 3; 32: 2).
- Each wait cycle (memack=0) adds exactly one cycle.
- instr_valid falls the cycle after acceptance or redirect.

## Test plan
- Reset/first fetch: WIDTH=8, MEMW=8, RESET_PC=0x10, memack=1, memory bytes 0x10..0x13 = 78 56 34 12. Required: memread first high 2 cycles after reset release; adr 10,11,12,13; instr_valid with instr=0x12345678, instr_pc=0x10, pc_next=0x14. All outputs at reset values while reset=0.
- Width variants: MEMW=16 then MEMW=32, same image. Required: adr sequence 10,12 and 10 respectively; same instr; valid after 2 and 1 fetch cycles.
- Wait states and backpressure: memack low 3 cycles on beat 2, instr_ready low 4 cycles in HOLD. Required: adr held at 0x12 for the stall, instr/instr_valid stable, next fetch starts at 0x14 only after ready.
- Redirect mid-fetch: redirect=1, redirect_pc=0x40 with memack=1 on beat 1. Required: beat discarded, next cycle adr=0x40, instr_pc=0x40 when valid.
- Simultaneous redirect and instr_ready in HOLD, redirect_pc=0x80. Required: next fetch at 0x80, not pc+4; instr_valid low for one cycle. Reset asserted during HOLD: instr_valid drops immediately.
- Wrap-around: WIDTH=8, instruction at 0xFC accepted. Required: next adr=0x00, pc_next=0x00.
